// File: rtl/ho_pkg.sv
// ho_pkg: shared handover types and widths for the base-station responder and the demux.
package ho_pkg;
    localparam int SQ_W = 2;
    localparam int TGT_W = 2;
    localparam logic [TGT_W-1:0] NO_TARGET = 2'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RESP, ST_SQ, ST_BACKOFF} bs_state_t;
endpackage

// File: rtl/ho_fifo.sv
// ho_fifo: 4-deep synchronous FIFO with full/empty flags and async active-low reset.
module ho_fifo #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [4];
    logic [W-1:0] mem_d [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full  = cnt_q == 3'd4;
    assign empty = cnt_q == 3'd0;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + 2'(do_push);
        rd_d  = rd_q + 2'(do_pop);
        cnt_d = cnt_q + 3'(do_push) - 3'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bs_ho_responder.sv
// bs_ho_responder: base-station end of the handover request/respond protocol.
// Define BS_HO_TIMEOUT_EN to enable REQ timeout, BACKOFF and drop counting.
module bs_ho_responder
    import ho_pkg::*;
#(
    parameter logic [TGT_W-1:0] BS_ID   = 2'd0,
    parameter int               DATA_W  = 4,
    parameter logic [SQ_W-1:0]  SQ_MIN  = 2'd1,
    parameter int               TIMEOUT = 16,
    parameter int               BACKOFF = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic [TGT_W-1:0]  DM_BS_target,
    input  logic [SQ_W-1:0]   DM_BS_sq,
    output logic              BS_DM_request,
    output logic              BS_DM_respond,
    output logic [DATA_W-1:0] BS_DM_data,
    output logic [SQ_W-1:0]   link_sq,
    output logic              link_weak,
    output logic [7:0]        drop_cnt
);
    localparam int CNT_W = $clog2((TIMEOUT > BACKOFF ? TIMEOUT : BACKOFF) + 1);

    bs_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d, fifo_head;
    logic [SQ_W-1:0] link_sq_q, link_sq_d;
    logic link_weak_q, link_weak_d;
    logic fifo_full, fifo_empty, grant, timeout, bo_done;

    ho_fifo #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (src_valid),
        .pop   (BS_DM_respond),
        .din   (src_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign src_ready = !fifo_full;
    assign grant     = state_q == ST_REQ && DM_BS_target == BS_ID && DM_BS_target != NO_TARGET;
    assign bo_done   = cnt_q == CNT_W'(BACKOFF - 1);

`ifdef BS_HO_TIMEOUT_EN
    logic [7:0] drop_q, drop_d;
    assign timeout  = state_q == ST_REQ && !grant && cnt_q == CNT_W'(TIMEOUT - 1);
    assign drop_d   = (timeout && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    assign drop_cnt = drop_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= '0;
        else drop_q <= drop_d;
    end
`else
    assign timeout  = 1'b0;
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = fifo_empty ? ST_IDLE : ST_REQ;
            ST_REQ:     state_d = grant ? ST_RESP : timeout ? ST_BACKOFF : ST_REQ;
            ST_RESP:    state_d = ST_SQ;
            ST_SQ:      state_d = ST_IDLE;
            ST_BACKOFF: state_d = bo_done ? ST_IDLE : ST_BACKOFF;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BS_DM_request = state_q == ST_REQ;
        BS_DM_respond = state_q == ST_RESP;
    end

    // Wait/backoff counter restarts on every state change, so each REQ entry starts at zero.
    always_comb begin
        cnt_d       = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        data_d      = grant ? fifo_head : data_q;
        link_sq_d   = state_q == ST_SQ ? DM_BS_sq : link_sq_q;
        link_weak_d = state_q == ST_SQ ? (DM_BS_sq < SQ_MIN) : link_weak_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            data_q      <= '0;
            link_sq_q   <= '0;
            link_weak_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            link_sq_q   <= link_sq_d;
            link_weak_q <= link_weak_d;
        end
    end

    assign BS_DM_data = data_q;
    assign link_sq    = link_sq_q;
    assign link_weak  = link_weak_q;
endmodule

// File: tb/tb_bs_ho_responder.sv
// tb_bs_ho_responder: directed bench with a payload scoreboard checked on every respond.
module tb_bs_ho_responder;
    localparam logic [1:0] ID = 2'd1;
    localparam logic [1:0] NT = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic src_valid = 1'b0;
    logic [3:0] src_data = '0;
    logic src_ready;
    logic [1:0] DM_BS_target = NT;
    logic [1:0] DM_BS_sq = '0;
    logic BS_DM_request, BS_DM_respond;
    logic [3:0] BS_DM_data;
    logic [1:0] link_sq;
    logic link_weak;
    logic [7:0] drop_cnt;

    int pass_n = 0;
    int fail_n = 0;
    int total_n = 0;
    int cyc = 0;
    logic [3:0] exp_q[$];
    int rsp_times[$];

    bs_ho_responder #(.BS_ID(ID), .DATA_W(4), .SQ_MIN(2'd1), .TIMEOUT(16), .BACKOFF(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .DM_BS_target  (DM_BS_target),
        .DM_BS_sq      (DM_BS_sq),
        .BS_DM_request (BS_DM_request),
        .BS_DM_respond (BS_DM_respond),
        .BS_DM_data    (BS_DM_data),
        .link_sq       (link_sq),
        .link_weak     (link_weak),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && BS_DM_respond) begin
            rsp_times.push_back(cyc);
            if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else check("rsp_data", 32'(BS_DM_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_val(input logic [3:0] v);
        src_valid = 1'b1;
        src_data  = v;
        if (src_ready) exp_q.push_back(v);
        tick();
        src_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (BS_DM_respond) seen = 1;
            else tick();
        end
        check("wait_rsp", 32'(seen), 32'd1);
    endtask

    task automatic grant_with_sq(input logic [1:0] sq);
        DM_BS_target = ID;
        wait_rsp(40);
        DM_BS_target = NT;
        DM_BS_sq = 2'bxx;
        tick();
        DM_BS_sq = sq;
        tick();
        DM_BS_sq = 2'bxx;
    endtask

    initial begin
        int n;
        int base;
        tick();
        tick();
        check("rst_request", 32'(BS_DM_request), 32'd0);
        check("rst_respond", 32'(BS_DM_respond), 32'd0);
        check("rst_data", 32'(BS_DM_data), 32'd0);
        check("rst_link_sq", 32'(link_sq), 32'd0);
        check("rst_link_weak", 32'(link_weak), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd1);
        reset = 1'b1;
        tick();
        push_val(4'hA);
        check("t1_idle_after_push", 32'(BS_DM_request), 32'd0);
        tick();
        check("t1_request_up", 32'(BS_DM_request), 32'd1);
        DM_BS_target = ID;
        wait_rsp(5);
        DM_BS_target = NT;
        DM_BS_sq = 2'bxx;
        tick();
        check("t1_respond_one_cycle", 32'(BS_DM_respond), 32'd0);
        DM_BS_sq = 2'd2;
        tick();
        DM_BS_sq = 2'bxx;
        check("t1_link_sq", 32'(link_sq), 32'd2);
        check("t1_link_weak", 32'(link_weak), 32'd0);
        check("t1_request_low", 32'(BS_DM_request), 32'd0);
        base = rsp_times.size();
        DM_BS_target = ID;
        DM_BS_sq = 2'd1;
        push_val(4'h3);
        push_val(4'h5);
        repeat (12) tick();
        DM_BS_target = NT;
        tick();
        check("t2_rsp_count", 32'(rsp_times.size() - base), 32'd2);
        if (rsp_times.size() - base == 2) check("t2_rsp_gap", 32'(rsp_times[base + 1] - rsp_times[base]), 32'd4);
        check("t2_fifo_empty", 32'(exp_q.size()), 32'd0);
        check("t2_request_low", 32'(BS_DM_request), 32'd0);
        check("t2_link_sq", 32'(link_sq), 32'd1);
        DM_BS_sq = 2'bxx;
        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1;
            src_data  = 4'(i + 1);
            if (src_ready) exp_q.push_back(4'(i + 1));
            tick();
            if (i == 3) check("t3_full_after_4", 32'(src_ready), 32'd0);
        end
        src_valid = 1'b0;
        check("t3_still_full", 32'(src_ready), 32'd0);
        check("t3_sb_depth", 32'(exp_q.size()), 32'd4);
        base = rsp_times.size();
        DM_BS_target = ID;
        DM_BS_sq = 2'd2;
        repeat (24) tick();
        DM_BS_target = NT;
        DM_BS_sq = 2'bxx;
        tick();
        check("t3_rsp_count", 32'(rsp_times.size() - base), 32'd4);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_src_ready", 32'(src_ready), 32'd1);
`ifdef BS_HO_TIMEOUT_EN
        push_val(4'hB);
        n = 0;
        while (!BS_DM_request && n < 10) begin tick(); n++; end
        n = 0;
        while (BS_DM_request && n < 40) begin tick(); n++; end
        check("to_req_cycles", 32'(n), 32'd16);
        check("to_drop_cnt", 32'(drop_cnt), 32'd1);
        n = 0;
        while (!BS_DM_request && n < 40) begin tick(); n++; end
        check("to_backoff_cycles", 32'(n), 32'd9);
        grant_with_sq(2'd2);
`else
        push_val(4'hB);
        repeat (30) tick();
        check("noto_request_held", 32'(BS_DM_request), 32'd1);
        check("noto_drop_cnt", 32'(drop_cnt), 32'd0);
        grant_with_sq(2'd2);
`endif
        tick();
        push_val(4'h7);
        grant_with_sq(2'd0);
        check("weak_link_sq", 32'(link_sq), 32'd0);
        check("weak_link_weak", 32'(link_weak), 32'd1);
        push_val(4'hE);
        grant_with_sq(2'd3);
        repeat (6) tick();
        check("hold_link_sq", 32'(link_sq), 32'd3);
        check("hold_link_weak", 32'(link_weak), 32'd0);
        push_val(4'h9);
        DM_BS_target = ID;
        wait_rsp(10);
        #1 reset = 1'b0;
        #1;
        check("rr_respond", 32'(BS_DM_respond), 32'd0);
        check("rr_request", 32'(BS_DM_request), 32'd0);
        check("rr_data", 32'(BS_DM_data), 32'd0);
        check("rr_link_sq", 32'(link_sq), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("rr_idle_request", 32'(BS_DM_request), 32'd0);
        check("rr_idle_respond", 32'(BS_DM_respond), 32'd0);
        check("rr_src_ready", 32'(src_ready), 32'd1);
        push_val(4'hD);
        wait_rsp(10);
        DM_BS_target = NT;
        repeat (4) tick();
        check("rr_final_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
